condicionador_de_entradas: RTL and testbench
============================================

# condicionador_de_entradas

Input-conditioning stage that sits directly upstream of the permission/priority/decoding logic of the vehicle-control design. It synchronises and debounces the eight slide switches and four active-low push-buttons. It presents stable user codes, and latches each user's momentary button presses into a held 3-bit functionality request, so downstream combinational logic sees clean, persistent codes instead of raw bouncing pins.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive cycles an input must differ from its filtered value before the filtered value changes (10 ms at 50 MHz).
- CAPTURE_CYCLES, 2500000: length of the button-combination capture window (50 ms at 50 MHz).
- SYNC_STAGES, 2: synchroniser flops per input (≥2).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- CH  in  8  raw switches; CH[0] is CH0.
- BTN  in  4  raw buttons, active-low (0 = pressed); BTN[0] is BTN0.
- User0  out  3  {CH0,CH1,CH2} filtered.
- User1  out  3  {CH4,CH5,CH6} filtered.
- Func0_NV  out  3  latched request of user 0: {CH3, BTN0 pressed, BTN1 pressed}.
- Func1_NV  out  3  latched request of user 1: {CH7, BTN2 pressed, BTN3 pressed}.
- Func0_Valid, Func1_Valid  out  1 each  one-cycle pulse when the matching Func*_NV is updated by a completed capture.
- Busy0, Busy1  out  1 each  high while that user's capture window is open.

## Operation
- Each of the 12 inputs passes through a SYNC_STAGES flop chain and then a debounce filter. Button levels are inverted to active-high "pressed" after synchronisation.
- Debounce filter per bit: counter resets to 0 whenever the synced value equals the filtered value. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the filtered value takes the synced value and the counter clears. Any agreeing cycle resets the count, so pulses shorter than DEBOUNCE_CYCLES never pass.
- The filter emits a one-cycle change event on the cycle its filtered value toggles.
- Per-user capture FSM, two independent instances. States: IDLE and CAPTURE.
- IDLE → CAPTURE on a press event (filtered 0→1) of either of the user's buttons, or on any change event of the user's MSB switch (CH3 or CH7). On entry: cap ← current filtered pressed bits, timer ← 0.
- In CAPTURE, each cycle: cap ← cap | pressed bits; timer increments. At timer = CAPTURE_CYCLES-1: Func*_NV ← {filtered MSB switch, cap}, Valid pulses, → IDLE.
- This makes code 100 reachable by switching the MSB on with no button pressed, and code 000 reachable by switching it off.
- Button releases and events arriving inside CAPTURE do not restart the window.
- A change event on any bit of a user's code switches clears that user's Func*_NV to 000, clears cap and forces IDLE, aborting any open window with no Valid pulse. If this coincides with window completion, the clear wins.
- Func*_NV holds its value indefinitely between updates.

## Timing
- Reset values: all outputs 0. Synchroniser and filtered switch state reset to 0. Button synchroniser and filtered state reset to released (raw 1), so held buttons at reset exit do not create events until they pass the debounce filter.
- Raw edge to filtered output: SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
- Filtered press to Busy high: 1 edge.
- Busy high to Func*_NV/Valid: CAPTURE_CYCLES edges. Busy falls on the same edge that Valid rises.
- User code change clears Func*_NV 1 edge after the filtered change.
- Counters are sized $clog2(param)+1 bits and never wrap.
- rst mid-capture returns to reset values on the next edge with no Valid pulse.
- Users 0 and 1 are fully independent. Simultaneous events on both are handled in the same cycle.

## Structure
- Package condicionador_pkg: FSM state enum {IDLE, CAPTURE}, button idle level constant, bit-index constants mapping CH/BTN positions to users.
- Natural sub-module filtro_debounce (synchroniser + filter + change/press event, parameterised by SYNC_STAGES, DEBOUNCE_CYCLES, reset level), instantiated 12 times.
- The capture FSM stays inline, generated twice.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, CAPTURE_CYCLES=8, SYNC_STAGES=2.
- Reset with BTN=4'b1111, CH=0 held 10 cycles → all outputs 0, Busy0/Busy1 0.
- BTN[0] low 3 cycles → no output change. BTN[0] low 20 cycles with CH3=0 → Busy0 high 7 edges after press; Func0_NV=010 and Func0_Valid single pulse 8 edges later.
- BTN[0] pressed, BTN[1] pressed 2 cycles later, CH3=1 → Func0_NV=111 and exactly one Valid pulse.
- CH7 0→1 with no buttons → Func1_NV=100. Then CH7 1→0 → Func1_NV=000, each with one Valid pulse.
- User0 set 101, start capture, change CH0..2 to 001 mid-window → Func0_NV=000, no Valid, Busy0 low, User0=001.
- Both users press simultaneously, then rst asserted mid-window → both Func cleared, no Valid pulses, outputs 0 next edge.

Source files
------------

// File: rtl/condicionador_pkg.sv
// Shared types and index constants for the input-conditioning stage:
// capture FSM states, idle pin levels and the CH/BTN-to-user mapping.
package condicionador_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_e;

  localparam logic BTN_IDLE_LEVEL = 1'b1;
  localparam logic CH_IDLE_LEVEL  = 1'b0;

  localparam int NUM_USERS    = 2;
  localparam int CH_PER_USER  = 4;
  localparam int BTN_PER_USER = 2;
  localparam int CODE_W       = 3;
  localparam int MSB_CH_OFF   = 3;

  // CH[base+0] is the code MSB shown to downstream logic
  function automatic logic [CODE_W-1:0] code_of(input logic [CODE_W-1:0] lvl);
    return {lvl[0], lvl[1], lvl[2]};
  endfunction

endpackage

// File: rtl/condicionador_de_entradas_filtro.sv
// filtro_debounce: synchroniser chain plus counting debounce filter for one
// pin, with a one-cycle change event aligned to the new filtered level.
module filtro_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic change_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   change_q, change_d;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      change_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      change_q <= change_d;
    end
  end

  // Any agreeing sample restarts the count, so short pulses never pass
  always_comb begin
    level_d  = level_q;
    cnt_d    = '0;
    change_d = 1'b0;
    if (synced_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d  = synced_s;
      change_d = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign level_o  = level_q;
  assign change_o = change_q;

endmodule

// File: rtl/condicionador_de_entradas.sv
// Input conditioning: debounces 8 switches and 4 active-low buttons and
// latches each user's button combination into a held 3-bit request.
module condicionador_de_entradas
  import condicionador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CAPTURE_CYCLES  = 2500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] CH,
  input  logic [3:0] BTN,
  output logic [2:0] User0,
  output logic [2:0] User1,
  output logic [2:0] Func0_NV,
  output logic [2:0] Func1_NV,
  output logic       Func0_Valid,
  output logic       Func1_Valid,
  output logic       Busy0,
  output logic       Busy1
);

  localparam int TW = $clog2(CAPTURE_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CAPTURE_CYCLES - 1);

  logic [7:0] ch_lvl_s, ch_chg_s;
  logic [3:0] btn_lvl_s, btn_chg_s, pressed_s, press_evt_s;

  logic [CODE_W-1:0] code_s  [NUM_USERS];
  logic [CODE_W-1:0] func_s  [NUM_USERS];
  logic              valid_s [NUM_USERS];
  logic              busy_s  [NUM_USERS];

  for (genvar i = 0; i < 8; i++) begin : g_ch
    filtro_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (CH_IDLE_LEVEL)
    ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (CH[i]),
      .level_o (ch_lvl_s[i]),
      .change_o(ch_chg_s[i])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_btn
    filtro_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (BTN_IDLE_LEVEL)
    ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (BTN[j]),
      .level_o (btn_lvl_s[j]),
      .change_o(btn_chg_s[j])
    );
  end

  assign pressed_s   = ~btn_lvl_s;
  assign press_evt_s = btn_chg_s & pressed_s;

  for (genvar u = 0; u < NUM_USERS; u++) begin : g_user
    localparam int CB = u * CH_PER_USER;
    localparam int BB = u * BTN_PER_USER;

    cap_state_e        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        cap_q, cap_d, prs_s, cap_acc_s;
    logic [CODE_W-1:0] func_q, func_d;
    logic              valid_q, valid_d;
    logic              code_chg_s, start_s, msb_s;

    // First button of the pair lands in the middle bit of the request
    assign prs_s      = {pressed_s[BB], pressed_s[BB+1]};
    assign cap_acc_s  = cap_q | prs_s;
    assign msb_s      = ch_lvl_s[CB+MSB_CH_OFF];
    assign code_chg_s = |ch_chg_s[CB+2:CB];
    assign start_s    = press_evt_s[BB] | press_evt_s[BB+1] | ch_chg_s[CB+MSB_CH_OFF];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        timer_q <= '0;
        cap_q   <= 2'b00;
        func_q  <= 3'b000;
        valid_q <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        cap_q   <= cap_d;
        func_q  <= func_d;
        valid_q <= valid_d;
      end
    end

    // A user-code change overrides both window start and window completion
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cap_d   = cap_q;
      func_d  = func_q;
      valid_d = 1'b0;
      if (code_chg_s) begin
        state_d = IDLE;
        timer_d = '0;
        cap_d   = 2'b00;
        func_d  = 3'b000;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_s) begin
              state_d = CAPTURE;
              timer_d = '0;
              cap_d   = prs_s;
            end else begin
              state_d = IDLE;
            end
          end
          CAPTURE: begin
            cap_d = cap_acc_s;
            if (timer_q == TIMER_LAST) begin
              func_d  = {msb_s, cap_acc_s};
              valid_d = 1'b1;
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            timer_d = '0;
            cap_d   = 2'b00;
          end
        endcase
      end
    end

    assign code_s[u]  = code_of(ch_lvl_s[CB+2:CB]);
    assign func_s[u]  = func_q;
    assign valid_s[u] = valid_q;
    assign busy_s[u]  = (state_q == CAPTURE);
  end

  assign User0       = code_s[0];
  assign User1       = code_s[1];
  assign Func0_NV    = func_s[0];
  assign Func1_NV    = func_s[1];
  assign Func0_Valid = valid_s[0];
  assign Func1_Valid = valid_s[1];
  assign Busy0       = busy_s[0];
  assign Busy1       = busy_s[1];

endmodule

// File: tb/tb_condicionador_de_entradas.sv
// Bench for condicionador_de_entradas: directed table, hand-timed corner
// sequences and random pin activity checked against a cycle model.
module tb_condicionador_de_entradas;

  localparam int DEB  = 4;
  localparam int CAP  = 8;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ch;
  logic [3:0] btn;
  logic [2:0] user0, user1, func0, func1;
  logic       valid0, valid1, busy0, busy1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  condicionador_de_entradas #(
    .DEBOUNCE_CYCLES(DEB),
    .CAPTURE_CYCLES (CAP),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .CH         (ch),
    .BTN        (btn),
    .User0      (user0),
    .User1      (user1),
    .Func0_NV   (func0),
    .Func1_NV   (func1),
    .Func0_Valid(valid0),
    .Func1_Valid(valid1),
    .Busy0      (busy0),
    .Busy1      (busy1)
  );

  function automatic logic [15:0] pk(input logic [2:0] u0, input logic [2:0] u1,
                                     input logic [2:0] f0, input logic [2:0] f1,
                                     input logic v0, input logic v1,
                                     input logic b0, input logic b1);
    return {u0, u1, f0, f1, v0, v1, b0, b1};
  endfunction

  logic [15:0] dut_out;
  assign dut_out = pk(user0, user1, func0, func1, valid0, valid1, busy0, busy1);

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (bits 0-7 = CH, 8-11 = BTN) ----------------
  logic [SYNC-1:0] m_pipe [12];
  logic [DEB-1:0]  m_hist [12];
  logic [11:0]     m_filt, m_evt;
  logic [1:0]      m_busy, m_valid;
  logic [1:0]      m_cap  [2];
  logic [2:0]      m_func [2];
  int              m_end  [2];
  int              cyc = 0;

  task automatic model_step();
    logic [11:0] raw;
    logic        lvl, code_chg, start, synced;
    logic [1:0]  prs;
    int          cb, bb;
    raw = {btn, ch};
    cyc++;
    if (rst) begin
      for (int i = 0; i < 12; i++) begin
        lvl = (i >= 8);
        m_pipe[i] = {SYNC{lvl}};
        m_hist[i] = {DEB{lvl}};
        m_filt[i] = lvl;
      end
      m_evt = '0; m_busy = '0; m_valid = '0;
      for (int u = 0; u < 2; u++) begin
        m_cap[u] = '0; m_func[u] = '0; m_end[u] = 0;
      end
    end else begin
      // request logic sees the filter state from before this edge
      for (int u = 0; u < 2; u++) begin
        cb = 4 * u; bb = 8 + 2 * u;
        code_chg = m_evt[cb] | m_evt[cb+1] | m_evt[cb+2];
        prs      = {~m_filt[bb], ~m_filt[bb+1]};
        start    = m_evt[cb+3] | (m_evt[bb] & ~m_filt[bb]) | (m_evt[bb+1] & ~m_filt[bb+1]);
        m_valid[u] = 1'b0;
        if (code_chg) begin
          m_busy[u] = 1'b0; m_cap[u] = 2'b00; m_func[u] = 3'b000;
        end else if (!m_busy[u]) begin
          if (start) begin
            m_busy[u] = 1'b1; m_cap[u] = prs; m_end[u] = cyc + CAP;
          end
        end else begin
          m_cap[u] = m_cap[u] | prs;
          if (cyc == m_end[u]) begin
            m_func[u] = {m_filt[cb+3], m_cap[u]};
            m_valid[u] = 1'b1;
            m_busy[u] = 1'b0;
          end
        end
      end
      // filtered level flips once the last DEB synced samples all disagree
      for (int i = 0; i < 12; i++) begin
        synced    = m_pipe[i][SYNC-1];
        m_hist[i] = {m_hist[i][DEB-2:0], synced};
        m_evt[i]  = 1'b0;
        if (m_hist[i] == {DEB{~m_filt[i]}}) begin
          m_filt[i] = ~m_filt[i];
          m_evt[i]  = 1'b1;
        end
        m_pipe[i] = {m_pipe[i][SYNC-2:0], raw[i]};
      end
    end
  endtask

  function automatic logic [15:0] model_out();
    return pk({m_filt[0], m_filt[1], m_filt[2]}, {m_filt[4], m_filt[5], m_filt[6]},
              m_func[0], m_func[1], m_valid[0], m_valid[1], m_busy[0], m_busy[1]);
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) check("model", dut_out, model_out());
  end

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [7:0]  ch;
    logic [3:0]  btn;
    int          cycles;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [7:0] c, input logic [3:0] b,
                     input int n, input logic [15:0] e);
    vec_t v;
    v.name = nm; v.ch = c; v.btn = b; v.cycles = n; v.exp = e;
    vecs.push_back(v);
  endtask

  int pulses;

  initial begin
    add("idle",        8'h00,        4'hF, 5,  pk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    add("btn0_glitch", 8'h00,        4'hE, 3,  pk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    add("glitch_gone", 8'h00,        4'hF, 10, pk(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    add("u1_code",     8'b0101_0000, 4'hF, 8,  pk(3'b000, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    add("ch7_on_busy", 8'b1101_0000, 4'hF, 8,  pk(3'b000, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
    add("ch7_on_done", 8'b1101_0000, 4'hF, 8,  pk(3'b000, 3'b101, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0));
    add("ch7_off",     8'b0101_0000, 4'hF, 15, pk(3'b000, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0));
    add("u0_code",     8'b0101_0101, 4'hF, 8,  pk(3'b101, 3'b101, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

    rst = 1'b1; ch = 8'h00; btn = 4'hF;
    repeat (10) @(negedge clk);
    check("reset", dut_out, 16'h0000);
    rst = 1'b0;
    chk_en = 1'b1;

    foreach (vecs[k]) begin
      ch = vecs[k].ch; btn = vecs[k].btn;
      repeat (vecs[k].cycles) @(negedge clk);
      check(vecs[k].name, dut_out, vecs[k].exp);
    end

    // BTN0 press: Busy on edge 7, request and single Valid on edge 15
    btn = 4'hE;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("busy0_timing",  16'(busy0),  16'(k >= 7 && k < 15));
      check("valid0_timing", 16'(valid0), 16'(k == 15));
      check("func0_timing",  16'(func0),  (k >= 15) ? 16'h0002 : 16'h0000);
    end
    btn = 4'hF;
    repeat (12) @(negedge clk);

    // CH3 on with BTN0, BTN1 joins two cycles later
    pulses = 0;
    ch = 8'b0101_1101; btn = 4'hE;
    repeat (2) @(negedge clk);
    btn = 4'hC;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (valid0) pulses++;
    end
    check("combo_pulses", 16'(pulses), 16'd1);
    check("combo_code",   16'(func0),  16'h0007);
    btn = 4'hF;
    repeat (12) @(negedge clk);

    // open a window, then change CH0 so the code becomes 001
    pulses = 0;
    btn = 4'hE;
    repeat (3) @(negedge clk);
    ch = 8'b0101_1100;
    for (int k = 4; k <= 24; k++) begin
      @(negedge clk);
      if (valid0) pulses++;
      if (k == 9)  check("abort_before", 16'({busy0, func0}), 16'h000F);
      if (k == 10) check("abort_clear",  16'({busy0, func0}), 16'h0000);
    end
    check("abort_pulses", 16'(pulses), 16'd0);
    check("abort_user0",  16'({user0, busy0, func0}), 16'h0010);
    btn = 4'hF;
    repeat (12) @(negedge clk);

    // both users press together, reset lands mid-window
    btn = 4'h0;
    repeat (10) @(negedge clk);
    check("both_busy", 16'({busy0, busy1}), 16'h0003);
    rst = 1'b1; btn = 4'hF; ch = 8'h00;
    @(negedge clk);
    check("rst_mid", dut_out, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst", dut_out, 16'h0000);

    // random pin activity, model compares every cycle
    for (int s = 0; s < 300; s++) begin
      ch  = ch  ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      btn = btn ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
